// File: rtl/seq_pkg.sv
// Shared definitions for the sequential RV64 subset core: opcodes, FSM states, ALU ops and
// instruction classes.
package seq_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Dword  = 3'b011;
  localparam logic [2:0] F3Beq    = 3'b000;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StPcupd,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluOr  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsIAlu,
    ClsLd,
    ClsSd,
    ClsBeq,
    ClsIllegal
  } instr_class_e;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction classifier: IR fields -> {class, ALU op, immediate operand select}.
module seq_decoder
  import seq_pkg::*;
(
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  output instr_class_e cls_o,
  output alu_op_e      alu_op_o,
  output logic         alu_src_imm_o
);

  // Anything not matched below stays ClsIllegal.
  always_comb begin
    cls_o         = ClsIllegal;
    alu_op_o      = AluAdd;
    alu_src_imm_o = 1'b0;
    unique case (opcode_i)
      OpcR: begin
        if (funct3_i == F3AddSub && funct7_i == F7Base) begin
          cls_o = ClsR;
        end else if (funct3_i == F3AddSub && funct7_i == F7Sub) begin
          cls_o    = ClsR;
          alu_op_o = AluSub;
        end else if (funct3_i == F3Or && funct7_i == F7Base) begin
          cls_o    = ClsR;
          alu_op_o = AluOr;
        end else if (funct3_i == F3And && funct7_i == F7Base) begin
          cls_o    = ClsR;
          alu_op_o = AluAnd;
        end
      end
      OpcIAlu: begin
        alu_src_imm_o = 1'b1;
        case (funct3_i)
          F3AddSub: cls_o = ClsIAlu;
          F3Or: begin
            cls_o    = ClsIAlu;
            alu_op_o = AluOr;
          end
          F3And: begin
            cls_o    = ClsIAlu;
            alu_op_o = AluAnd;
          end
          default: ;
        endcase
      end
      OpcLoad: begin
        if (funct3_i == F3Dword) begin
          cls_o         = ClsLd;
          alu_src_imm_o = 1'b1;
        end
      end
      OpcStore: begin
        if (funct3_i == F3Dword) begin
          cls_o         = ClsSd;
          alu_src_imm_o = 1'b1;
        end
      end
      OpcBranch: begin
        if (funct3_i == F3Beq) begin
          cls_o    = ClsBeq;
          alu_op_o = AluSub;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_control_fsm.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, write-back and PC update, with a
// memory wait timeout, sticky error flags and a retired-instruction counter.
module seq_control_fsm
  import seq_pkg::*;
#(
  // Must be at least 1.
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  input  logic        dmem_ready_i,
  input  logic        alu_zero_i,
  output logic [31:0] instr_o,
  output logic        imem_req_o,
  output logic        dmem_re_o,
  output logic        dmem_we_o,
  output logic        alu_src_imm_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_we_o,
  output logic        wb_sel_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic        halted_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [31:0] instret_o
);

  // The counter only ever holds 0..TIMEOUT-1; the last unready cycle halts instead of counting.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic            taken_q, taken_d;
  logic [31:0]     instret_q, instret_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  // Registered Moore outputs, computed from the next state.
  logic    dmem_re_q, dmem_re_d;
  logic    dmem_we_q, dmem_we_d;
  logic    alu_src_imm_q, alu_src_imm_d;
  alu_op_e alu_op_q, alu_op_d;
  logic    reg_we_q, reg_we_d;
  logic    wb_sel_q, wb_sel_d;
  logic    pc_we_q, pc_we_d;
  logic    pc_sel_q, pc_sel_d;
  logic    halted_q, halted_d;

  instr_class_e dec_cls;
  alu_op_e      dec_alu_op;
  logic         dec_src_imm;

  seq_decoder u_decoder (
    .opcode_i      (ir_q[6:0]),
    .funct3_i      (ir_q[14:12]),
    .funct7_i      (ir_q[31:25]),
    .cls_o         (dec_cls),
    .alu_op_o      (dec_alu_op),
    .alu_src_imm_o (dec_src_imm)
  );

  // run only matters in FETCH; it is not a ready input, so the direct path is allowed.
  assign imem_req_o = (state_q == StFetch) && run_i;

  // State transitions, IR capture, wait counting and retirement.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    taken_d   = taken_q;
    instret_d = instret_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StFetch: begin
        if (run_i) begin
          if (imem_ready_i) begin
            ir_d    = imem_rdata_i;
            state_d = StDecode;
          end else if (wait_q == WaitLast) begin
            bus_err_d = 1'b1;
            state_d   = StHalt;
          end else begin
            wait_d = wait_q + CntW'(1);
          end
        end
      end
      StDecode: begin
        if (dec_cls == ClsIllegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (dec_cls)
          ClsR, ClsIAlu: state_d = StWb;
          ClsLd, ClsSd: begin
            wait_d  = '0;
            state_d = StMem;
          end
          ClsBeq: begin
            taken_d = alu_zero_i;
            state_d = StPcupd;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        // Ready in the final allowed cycle still completes the access.
        if (dmem_ready_i) begin
          state_d = (dec_cls == ClsLd) ? StWb : StPcupd;
        end else if (wait_q == WaitLast) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      StWb: state_d = StPcupd;
      StPcupd: begin
        instret_d = instret_q + 32'd1;
        wait_d    = '0;
        state_d   = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // Output strobes for the state being entered, so they appear with the state itself.
  always_comb begin
    dmem_re_d     = (state_d == StMem) && (dec_cls == ClsLd);
    dmem_we_d     = (state_d == StMem) && (dec_cls == ClsSd);
    alu_op_d      = AluAdd;
    alu_src_imm_d = 1'b0;
    if (state_d == StExec || state_d == StMem) begin
      alu_op_d      = dec_alu_op;
      alu_src_imm_d = dec_src_imm;
    end
    reg_we_d = (state_d == StWb);
    wb_sel_d = (state_d == StWb) && (dec_cls == ClsLd);
    pc_we_d  = (state_d == StPcupd);
    pc_sel_d = (state_d == StPcupd) && (dec_cls == ClsBeq) && taken_d;
    halted_d = (state_d == StHalt);
  end

  // All state and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      ir_q          <= '0;
      taken_q       <= 1'b0;
      instret_q     <= '0;
      wait_q        <= '0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      dmem_re_q     <= 1'b0;
      dmem_we_q     <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_op_q      <= AluAdd;
      reg_we_q      <= 1'b0;
      wb_sel_q      <= 1'b0;
      pc_we_q       <= 1'b0;
      pc_sel_q      <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      taken_q       <= taken_d;
      instret_q     <= instret_d;
      wait_q        <= wait_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
      dmem_re_q     <= dmem_re_d;
      dmem_we_q     <= dmem_we_d;
      alu_src_imm_q <= alu_src_imm_d;
      alu_op_q      <= alu_op_d;
      reg_we_q      <= reg_we_d;
      wb_sel_q      <= wb_sel_d;
      pc_we_q       <= pc_we_d;
      pc_sel_q      <= pc_sel_d;
      halted_q      <= halted_d;
    end
  end

  assign instr_o       = ir_q;
  assign dmem_re_o     = dmem_re_q;
  assign dmem_we_o     = dmem_we_q;
  assign alu_src_imm_o = alu_src_imm_q;
  assign alu_op_o      = alu_op_q;
  assign reg_we_o      = reg_we_q;
  assign wb_sel_o      = wb_sel_q;
  assign pc_we_o       = pc_we_q;
  assign pc_sel_o      = pc_sel_q;
  assign halted_o      = halted_q;
  assign illegal_o     = illegal_q;
  assign bus_err_o     = bus_err_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_seq_control_fsm.sv
// Bench for seq_control_fsm: a phase-list reference model checked every cycle, directed
// instruction scenarios with literal expectations, then randomized traffic with resets.
module tb_seq_control_fsm;

  localparam int unsigned TO = 4;

  localparam byte PhF = "F";
  localparam byte PhD = "D";
  localparam byte PhE = "E";
  localparam byte PhM = "M";
  localparam byte PhW = "W";
  localparam byte PhP = "P";
  localparam byte PhH = "H";

  localparam int KR = 0, KI = 1, KLd = 2, KSd = 3, KBeq = 4, KIll = -1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_ready;
  logic        alu_zero;
  logic [31:0] instr;
  logic        imem_req, dmem_re, dmem_we, alu_src_imm;
  logic [1:0]  alu_op;
  logic        reg_we, wb_sel, pc_we, pc_sel, halted, illegal, bus_err;
  logic [31:0] instret;

  always #5 clk = ~clk;

  seq_control_fsm #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run_i         (run),
    .imem_rdata_i  (imem_rdata),
    .imem_ready_i  (imem_ready),
    .dmem_ready_i  (dmem_ready),
    .alu_zero_i    (alu_zero),
    .instr_o       (instr),
    .imem_req_o    (imem_req),
    .dmem_re_o     (dmem_re),
    .dmem_we_o     (dmem_we),
    .alu_src_imm_o (alu_src_imm),
    .alu_op_o      (alu_op),
    .reg_we_o      (reg_we),
    .wb_sel_o      (wb_sel),
    .pc_we_o       (pc_we),
    .pc_sel_o      (pc_sel),
    .halted_o      (halted),
    .illegal_o     (illegal),
    .bus_err_o     (bus_err),
    .instret_o     (instret)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the remaining phases of the current instruction, front = this cycle.
  byte         m_plan[$];
  logic [31:0] m_ir;
  int          m_kind;
  logic [1:0]  m_aop;
  logic        m_src;
  logic        m_taken;
  logic [31:0] m_instret;
  logic        m_illegal, m_bus_err;
  int          m_waits;

  int obs_re, obs_we, obs_rwe, obs_pwe, obs_pcsel, obs_wbsel, obs_req, obs_cyc;
  logic [1:0] obs_aop2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void spec_decode(input logic [31:0] w, output int kind,
                                      output logic [1:0] aop, output logic src);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc  = w[6:0];
    f3   = w[14:12];
    f7   = w[31:25];
    kind = KIll;
    aop  = 2'b00;
    src  = 1'b0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'h00 && f3 == 3'd0) kind = KR;
        else if (f7 == 7'h20 && f3 == 3'd0) begin kind = KR; aop = 2'b01; end
        else if (f7 == 7'h00 && f3 == 3'd6) begin kind = KR; aop = 2'b11; end
        else if (f7 == 7'h00 && f3 == 3'd7) begin kind = KR; aop = 2'b10; end
      end
      7'b0010011: begin
        src = 1'b1;
        if (f3 == 3'd0) kind = KI;
        else if (f3 == 3'd6) begin kind = KI; aop = 2'b11; end
        else if (f3 == 3'd7) begin kind = KI; aop = 2'b10; end
      end
      7'b0000011: if (f3 == 3'd3) begin kind = KLd; src = 1'b1; end
      7'b0100011: if (f3 == 3'd3) begin kind = KSd; src = 1'b1; end
      7'b1100011: if (f3 == 3'd0) begin kind = KBeq; aop = 2'b01; end
      default: ;
    endcase
  endfunction

  task automatic build_plan();
    m_plan.delete();
    m_plan.push_back(PhD);
    case (m_kind)
      KR, KI: begin m_plan.push_back(PhE); m_plan.push_back(PhW); m_plan.push_back(PhP); end
      KLd: begin
        m_plan.push_back(PhE); m_plan.push_back(PhM);
        m_plan.push_back(PhW); m_plan.push_back(PhP);
      end
      KSd: begin m_plan.push_back(PhE); m_plan.push_back(PhM); m_plan.push_back(PhP); end
      KBeq: begin m_plan.push_back(PhE); m_plan.push_back(PhP); end
      default: m_plan.push_back(PhH);
    endcase
  endtask

  task automatic halt_plan();
    m_plan.delete();
    m_plan.push_back(PhH);
  endtask

  task automatic model_reset();
    m_plan.delete();
    m_plan.push_back(PhF);
    m_ir      = '0;
    m_kind    = KIll;
    m_aop     = 2'b00;
    m_src     = 1'b0;
    m_taken   = 1'b0;
    m_instret = '0;
    m_illegal = 1'b0;
    m_bus_err = 1'b0;
    m_waits   = 0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_adv();
    byte ph = m_plan[0];
    case (ph)
      PhF: begin
        if (run) begin
          if (imem_ready) begin
            m_ir = imem_rdata;
            spec_decode(m_ir, m_kind, m_aop, m_src);
            build_plan();
            m_waits = 0;
          end else begin
            m_waits++;
            if (m_waits == int'(TO)) begin m_bus_err = 1'b1; halt_plan(); end
          end
        end
      end
      PhD: begin
        void'(m_plan.pop_front());
        if (m_plan[0] == PhH) m_illegal = 1'b1;
      end
      PhE: begin
        if (m_kind == KBeq) m_taken = alu_zero;
        void'(m_plan.pop_front());
      end
      PhM: begin
        if (dmem_ready) begin
          void'(m_plan.pop_front());
          m_waits = 0;
        end else begin
          m_waits++;
          if (m_waits == int'(TO)) begin m_bus_err = 1'b1; halt_plan(); end
        end
      end
      PhW: void'(m_plan.pop_front());
      PhP: begin
        m_instret = m_instret + 32'd1;
        void'(m_plan.pop_front());
      end
      default: ;
    endcase
    if (m_plan.size() == 0) begin
      m_plan.push_back(PhF);
      m_waits = 0;
    end
  endtask

  task automatic check_model();
    byte ph = m_plan[0];
    chk("imem_req", imem_req, (ph == PhF) && run);
    chk("dmem_re", dmem_re, (ph == PhM) && (m_kind == KLd));
    chk("dmem_we", dmem_we, (ph == PhM) && (m_kind == KSd));
    chk("reg_we", reg_we, ph == PhW);
    chk("pc_we", pc_we, ph == PhP);
    chk("halted", halted, ph == PhH);
    chk("illegal", illegal, m_illegal);
    chk("bus_err", bus_err, m_bus_err);
    chk("instret", instret, m_instret);
    chk("instr", instr, m_ir);
    if (ph == PhE || ph == PhM) begin
      chk("alu_op", alu_op, m_aop);
      chk("alu_src_imm", alu_src_imm, m_src);
    end
    if (ph == PhW) chk("wb_sel", wb_sel, m_kind == KLd);
    if (ph == PhP) chk("pc_sel", pc_sel, (m_kind == KBeq) && m_taken);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    check_model();
    if (dmem_re) obs_re++;
    if (dmem_we) obs_we++;
    if (reg_we) obs_rwe++;
    if (pc_we) obs_pwe++;
    if (pc_we && pc_sel) obs_pcsel++;
    if (reg_we && wb_sel) obs_wbsel++;
    if (imem_req) obs_req++;
    if (obs_cyc == 2) obs_aop2 = alu_op;
    obs_cyc++;
    @(posedge clk);
    model_adv();
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_re = 0; obs_we = 0; obs_rwe = 0; obs_pwe = 0;
    obs_pcsel = 0; obs_wbsel = 0; obs_req = 0; obs_cyc = 0; obs_aop2 = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_reg_we", reg_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instret", instret, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One instruction: fetch with zero wait, data ready after mdelay MEM cycles.
  task automatic run_instr(input logic [31:0] w, input int mdelay, input logic az,
                           output int cyc);
    int memc = 0;
    clear_obs();
    cyc        = 0;
    imem_rdata = w;
    imem_ready = 1'b1;
    alu_zero   = az;
    do begin
      run        = (cyc == 0);
      dmem_ready = (m_plan[0] == PhM) && (memc >= mdelay);
      if (m_plan[0] == PhM) memc++;
      step();
      cyc++;
    end while (m_plan[0] != PhF && m_plan[0] != PhH && cyc < 40);
    if (cyc >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL instr_bound: got %0d cycles, expected completion", cyc);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int s;
    w = $urandom;
    s = int'($urandom_range(0, 2));
    case ($urandom_range(0, 9))
      0: begin w[31:25] = 7'h00; w[14:12] = 3'd0; w[6:0] = 7'h33; end
      1: begin w[31:25] = 7'h20; w[14:12] = 3'd0; w[6:0] = 7'h33; end
      2: begin w[31:25] = 7'h00; w[14:12] = 3'd6; w[6:0] = 7'h33; end
      3: begin w[31:25] = 7'h00; w[14:12] = 3'd7; w[6:0] = 7'h33; end
      4: begin w[6:0] = 7'h13; w[14:12] = (s == 0) ? 3'd0 : (s == 1) ? 3'd6 : 3'd7; end
      5: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
      6: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
      7: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
      8: w[6:0] = 7'h33;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int cyc;
    int halt_cnt;
    rst_n = 1'b0; run = 1'b0; imem_rdata = '0; imem_ready = 1'b0;
    dmem_ready = 1'b0; alu_zero = 1'b0;
    model_reset();
    clear_obs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_instr", instr, 0);
    chk("reset_imem_req", imem_req, 0);
    chk("reset_strobes", {dmem_re, dmem_we, reg_we, pc_we, pc_sel}, 0);
    chk("reset_flags", {halted, illegal, bus_err}, 0);
    chk("reset_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // add x3,x1,x2
    run_instr(32'h002081B3, 0, 1'b0, cyc);
    chk("add_cycles", cyc, 5);
    chk("add_reg_we_cnt", obs_rwe, 1);
    chk("add_pc_we_cnt", obs_pwe, 1);
    chk("add_alu_op", obs_aop2, 2'b00);
    chk("add_instret", instret, 1);

    // ld x3,0(x1), data ready on the 4th MEM cycle (also the timeout boundary)
    run_instr(32'h0000B183, 3, 1'b0, cyc);
    chk("ld_cycles", cyc, 9);
    chk("ld_dmem_re_cnt", obs_re, 4);
    chk("ld_wb_sel", obs_wbsel, 1);
    chk("ld_bus_err", bus_err, 0);
    chk("ld_instret", instret, 2);

    // beq taken / not taken
    run_instr(32'h00208463, 0, 1'b1, cyc);
    chk("beq_t_cycles", cyc, 4);
    chk("beq_t_pc_sel", obs_pcsel, 1);
    chk("beq_t_reg_we", obs_rwe, 0);
    chk("beq_t_alu_op", obs_aop2, 2'b01);
    run_instr(32'h00208463, 0, 1'b0, cyc);
    chk("beq_nt_pc_sel", obs_pcsel, 0);
    chk("beq_nt_pc_we", obs_pwe, 1);
    chk("beq_instret", instret, 4);

    // sd x3,0(x1)
    run_instr(32'h0030B023, 0, 1'b0, cyc);
    chk("sd_cycles", cyc, 5);
    chk("sd_dmem_we_cnt", obs_we, 1);
    chk("sd_reg_we", obs_rwe, 0);
    chk("sd_instret", instret, 5);

    // illegal opcode halts and stays halted
    run_instr(32'h0000007F, 0, 1'b0, cyc);
    chk("ill_cycles", cyc, 2);
    chk("ill_illegal", illegal, 1);
    chk("ill_halted", halted, 1);
    clear_obs();
    run = 1'b1;
    repeat (4) step();
    chk("ill_no_req", obs_req, 0);
    chk("ill_instret", instret, 5);
    do_reset();

    // fetch timeout
    run = 1'b1; imem_ready = 1'b0;
    repeat (3) step();
    chk("to_not_yet", bus_err, 0);
    step();
    chk("to_bus_err", bus_err, 1);
    chk("to_halted", halted, 1);
    do_reset();

    // reset during WB
    clear_obs();
    imem_rdata = 32'h002081B3; imem_ready = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    #1;
    chk("midrst_in_wb", reg_we, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_we_drop", reg_we, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (3) step();
    chk("midrst_no_pc_we", obs_pwe, 0);
    chk("midrst_no_reg_we", obs_rwe, 0);
    chk("midrst_instret", instret, 0);

    // randomized traffic
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((m_plan[0] == PhH && halt_cnt >= 3) || $urandom_range(0, 199) == 0) begin
        do_reset();
        halt_cnt = 0;
      end
      run        = ($urandom_range(0, 9) < 8);
      imem_ready = ($urandom_range(0, 9) < 7);
      dmem_ready = ($urandom_range(0, 9) < 6);
      alu_zero   = 1'($urandom_range(0, 1));
      imem_rdata = gen_instr();
      if (m_plan[0] == PhH) halt_cnt++;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
